vga_pattern_sequencer: RTL and testbench

Frame-synchronous test-pattern scheduler between the VGA timing driver and its colour inputs. It watches the driver's pixel counters and detects frame boundaries. It selects one of several built-in patterns and switches patterns only at a frame start, either automatically every N frames or on a step request. It generates registered RGB for the current pattern.

---
 rtl/vga_pattern_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_vga_pattern_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_sequencer.sv
// Purpose : frame-synchronous test-pattern scheduler feeding registered RGB to a VGA timing driver.
// Latency : 1 clock from counter sample to vga_r/g/b; pattern switches take effect on the (0,0) pixel itself.
// Backpr. : none; follows the driver's pixel counters every clock, step requests made while one is pending are absorbed.
//
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   ctr_h, ctr_v      driver pixel counters (>= WIDTH / >= HEIGHT is blanking)
//   auto_en           level, auto-advance every FRAMES_PER_PATTERN frames (sampled at frame starts)
//   step_req          one-cycle pulse, advance at the next frame start
//   solid_rgb         {R,G,B} for the solid pattern
//   vga_r/g/b         registered colour
//   pattern_idx       pattern currently displayed
//   frame_start       one-cycle pulse after the edge that registers pixel (0,0) of a new frame
//
// Build option: define VGA_PATSEQ_BORDER_EN to add pattern 4 (one-pixel white border).

module vga_pattern_sequencer #(
    parameter int WIDTH              = 1024,
    parameter int HEIGHT             = 768,
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int CHK_LOG2           = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] ctr_h,
    input  logic [9:0]  ctr_v,
    input  logic        auto_en,
    input  logic        step_req,
    input  logic [23:0] solid_rgb,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic [2:0]  pattern_idx,
    output logic        frame_start
);

    localparam int LOG2W = $clog2(WIDTH);
    // A one-frame-per-pattern build still needs a (constant zero) counter bit.
    localparam int FCW   = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;

`ifdef VGA_PATSEQ_BORDER_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    localparam logic [2:0] PAT_BARS    = 3'd0;
    localparam logic [2:0] PAT_CHECKER = 3'd1;
    localparam logic [2:0] PAT_RAMP    = 3'd2;
    localparam logic [2:0] PAT_SOLID   = 3'd3;
`ifdef VGA_PATSEQ_BORDER_EN
    localparam logic [2:0] PAT_BORDER  = 3'd4;
`endif

    typedef enum logic {
        HOLD = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [10:0]      prev_h;
    logic [9:0]       prev_v;
    logic [FCW-1:0]   frame_cnt;
    logic [FCW-1:0]   frame_cnt_d;
    logic [2:0]       idx_d;
    logic             advance;
    logic             boundary;
    logic             auto_expire;
    logic             active;
    logic [2:0]       bar;
    logic             chk_bit;
    logic [7:0]       grey;
    logic [23:0]      rgb_d;

    // ------------------------------------------------------------------
    // Frame boundary: (0,0) now, and the previous sample was not (0,0).
    // A counter parked on (0,0) therefore yields a single boundary.
    // ------------------------------------------------------------------
    assign boundary = (ctr_h == 11'd0) && (ctr_v == 10'd0) &&
                      !((prev_h == 11'd0) && (prev_v == 10'd0));

    assign auto_expire = auto_en && (frame_cnt == FCW'(FRAMES_PER_PATTERN - 1));

    // ------------------------------------------------------------------
    // Sequencer next-state. Only one advance can happen per boundary, so
    // a step and an auto expiry landing together move one pattern.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        advance     = 1'b0;
        idx_d       = pattern_idx;
        frame_cnt_d = frame_cnt;

        case (state_q)
            HOLD: begin
                if (boundary) begin
                    // A step arriving on the boundary cycle is served immediately.
                    advance = step_req || auto_expire;
                end else if (step_req) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                // Further step pulses here are absorbed; nothing queues.
                if (boundary) begin
                    advance = 1'b1;
                    state_d = HOLD;
                end
            end
            default: state_d = HOLD;
        endcase

        if (advance) begin
            idx_d       = (pattern_idx >= LAST_IDX) ? 3'd0 : pattern_idx + 3'd1;
            frame_cnt_d = '0;
        end else if (boundary) begin
            frame_cnt_d = auto_en ? frame_cnt + 1'b1 : '0;
        end
    end

    // ------------------------------------------------------------------
    // Pixel generator. Uses idx_d so the first pixel of a new frame is
    // already drawn with the newly selected pattern.
    // ------------------------------------------------------------------
    assign active  = (ctr_h < 11'(WIDTH)) && (ctr_v < 10'(HEIGHT));
    // WIDTH is a power of two, so the top 3 / top 8 bits of the active
    // horizontal range give the bar number and the ramp level directly.
    assign bar     = ctr_h[LOG2W-1 -: 3];
    assign grey    = ctr_h[LOG2W-1 -: 8];
    assign chk_bit = ctr_h[CHK_LOG2] ^ ctr_v[CHK_LOG2];

    always_comb begin
        rgb_d = 24'h000000;
        if (active) begin
            case (idx_d)
                PAT_BARS: begin
                    // Bar bit 0 -> red, bit 1 -> green, bit 2 -> blue gives
                    // black, red, green, yellow, blue, magenta, cyan, white.
                    rgb_d = {{8{bar[0]}}, {8{bar[1]}}, {8{bar[2]}}};
                end
                PAT_CHECKER: begin
                    rgb_d = {24{chk_bit}};
                end
                PAT_RAMP: begin
                    rgb_d = {grey, grey, grey};
                end
                PAT_SOLID: begin
                    rgb_d = solid_rgb;
                end
`ifdef VGA_PATSEQ_BORDER_EN
                PAT_BORDER: begin
                    if ((ctr_h == 11'd0) || (ctr_h == 11'(WIDTH - 1)) ||
                        (ctr_v == 10'd0) || (ctr_v == 10'(HEIGHT - 1))) begin
                        rgb_d = 24'hFFFFFF;
                    end
                end
`endif
                default: rgb_d = 24'h000000;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers. prev_h/prev_v reset to all ones so a (0,0) sample on the
    // first cycle out of reset counts as a frame boundary.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HOLD;
            prev_h      <= '1;
            prev_v      <= '1;
            frame_cnt   <= '0;
            pattern_idx <= 3'd0;
            frame_start <= 1'b0;
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
        end else begin
            state_q     <= state_d;
            prev_h      <= ctr_h;
            prev_v      <= ctr_v;
            frame_cnt   <= frame_cnt_d;
            pattern_idx <= idx_d;
            frame_start <= boundary;
            vga_r       <= rgb_d[23:16];
            vga_g       <= rgb_d[15:8];
            vga_b       <= rgb_d[7:0];
        end
    end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Purpose : self-checking bench for vga_pattern_sequencer (sparse counter sequences, reference model + scoreboard).
// Latency : each driven sample is checked one clock later, #1 after the registering edge.
// Backpr. : none; stimulus is one sample per clock.

module tb_vga_pattern_sequencer;

    localparam int W   = 1024;
    localparam int H   = 768;
    localparam int FPP = 2;
`ifdef VGA_PATSEQ_BORDER_EN
    localparam int LAST = 4;
`else
    localparam int LAST = 3;
`endif

    typedef struct packed {
        logic [23:0] rgb;
        logic [2:0]  idx;
        logic        fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] ctr_h;
    logic [9:0]  ctr_v;
    logic        auto_en;
    logic        step_req;
    logic [23:0] solid_rgb;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [2:0]  pattern_idx;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_q[$];

    // Reference model state
    int m_idx, m_cnt, m_ph, m_pv;
    bit m_pend;

    vga_pattern_sequencer #(
        .WIDTH(W), .HEIGHT(H), .FRAMES_PER_PATTERN(FPP), .CHK_LOG2(5)
    ) dut (
        .clk(clk), .rst(rst), .ctr_h(ctr_h), .ctr_v(ctr_v),
        .auto_en(auto_en), .step_req(step_req), .solid_rgb(solid_rgb),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .pattern_idx(pattern_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_px(int idx, int h, int v, logic [23:0] solid);
        logic [7:0] g;
        if (h >= W || v >= H) return 24'h0;
        case (idx)
            0: case (h / 128)
                   0: return 24'h000000;
                   1: return 24'hFF0000;
                   2: return 24'h00FF00;
                   3: return 24'hFFFF00;
                   4: return 24'h0000FF;
                   5: return 24'hFF00FF;
                   6: return 24'h00FFFF;
                   default: return 24'hFFFFFF;
               endcase
            1: return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            2: begin
                g = 8'((h / 4) % 256);
                return {g, g, g};
            end
            3: return solid;
            4: return (h == 0 || h == W - 1 || v == 0 || v == H - 1) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h0;
        endcase
    endfunction

    // Drive one sample, push the model's expectation, then compare one clock later.
    task automatic drive(input int h, input int v, input bit a, input bit s, input bit r);
        exp_t e;
        bit   bnd;
        @(negedge clk);
        ctr_h    = 11'(h);
        ctr_v    = 10'(v);
        auto_en  = a;
        step_req = s;
        rst      = r;
        if (r) begin
            m_idx = 0; m_cnt = 0; m_pend = 0; m_ph = 2047; m_pv = 1023;
            e = '{rgb: 24'h0, idx: 3'd0, fs: 1'b0};
        end else begin
            bnd = (h == 0 && v == 0) && !(m_ph == 0 && m_pv == 0);
            if (bnd) begin
                if (m_pend || s || (a && m_cnt == FPP - 1)) begin
                    m_idx  = (m_idx == LAST) ? 0 : m_idx + 1;
                    m_cnt  = 0;
                    m_pend = 0;
                end else begin
                    m_cnt = a ? m_cnt + 1 : 0;
                end
            end else if (s) begin
                m_pend = 1;
            end
            m_ph = h;
            m_pv = v;
            e = '{rgb: model_px(m_idx, h, v, solid_rgb), idx: 3'(m_idx), fs: bnd};
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("rgb(%0d,%0d)", h, v), {8'h0, vga_r, vga_g, vga_b}, {8'h0, e.rgb});
            chk($sformatf("idx(%0d,%0d)", h, v), {29'h0, pattern_idx}, {29'h0, e.idx});
            chk($sformatf("fs(%0d,%0d)", h, v), {31'h0, frame_start}, {31'h0, e.fs});
        end
    endtask

    task automatic frame(input bit a);
        drive(0, 0, a, 0, 0);
        drive(128, 10, a, 0, 0);
        drive(900, 10, a, 0, 0);
        drive(1100, 700, a, 0, 0);
        drive(5, 800, a, 0, 0);
    endtask

    initial begin
        rst = 1'b1; ctr_h = '0; ctr_v = '0; auto_en = 1'b0; step_req = 1'b0;
        solid_rgb = 24'h123456;

        // Reset state
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("reset_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("reset_idx", {29'h0, pattern_idx}, 32'd0);
        chk("reset_fs", {31'h0, frame_start}, 32'd0);

        // No auto, no step: bars for three frames
        for (int f = 0; f < 3; f++) begin
            drive(0, 0, 0, 0, 0);
            chk("first_frame_start", {31'h0, frame_start}, 32'd1);
            drive(128, 10, 0, 0, 0);
            chk("bar_red", {8'h0, vga_r, vga_g, vga_b}, 32'hFF0000);
            drive(900, 10, 0, 0, 0);
            chk("bar_white", {8'h0, vga_r, vga_g, vga_b}, 32'hFFFFFF);
            drive(1100, 700, 0, 0, 0);
            chk("hold_idx", {29'h0, pattern_idx}, 32'd0);
        end

        // Auto advance every 2 frames, full wrap
        for (int f = 0; f < 2 * (LAST + 1); f++) frame(1);
        chk("auto_wrap_idx", {29'h0, pattern_idx}, 32'd0);

        // Step request mid-frame, applied only at next (0,0)
        frame(0);
        drive(500, 300, 0, 1, 0);
        drive(600, 300, 0, 0, 0);
        chk("step_not_early", {29'h0, pattern_idx}, 32'd0);
        drive(0, 0, 0, 0, 0);
        chk("step_idx", {29'h0, pattern_idx}, 32'd1);
        chk("chk_origin_black", {8'h0, vga_r, vga_g, vga_b}, 32'h000000);
        drive(32, 0, 0, 0, 0);
        chk("chk_32_white", {8'h0, vga_r, vga_g, vga_b}, 32'hFFFFFF);

        // Step coinciding with auto expiry: one advance
        drive(0, 0, 1, 0, 0);
        drive(40, 40, 1, 0, 0);
        drive(0, 0, 1, 1, 0);
        chk("simul_idx", {29'h0, pattern_idx}, 32'd2);
        drive(512, 0, 0, 0, 0);
        chk("ramp_512", {8'h0, vga_r, vga_g, vga_b}, 32'h808080);

        // Repeated steps while pending are absorbed
        drive(10, 10, 0, 1, 0);
        drive(20, 10, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        chk("absorb_idx", {29'h0, pattern_idx}, 32'd3);
        drive(0, 0, 0, 0, 0);
        chk("parked_no_fs", {31'h0, frame_start}, 32'd0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("absorb_no_second", {29'h0, pattern_idx}, 32'd3);

        // Solid pattern and blanking
        drive(100, 100, 0, 0, 0);
        chk("solid", {8'h0, vga_r, vga_g, vga_b}, 32'h123456);
        drive(1100, 5, 0, 0, 0);
        chk("blank", {8'h0, vga_r, vga_g, vga_b}, 32'h000000);

        // Last pattern / wrap
        drive(300, 300, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
`ifdef VGA_PATSEQ_BORDER_EN
        chk("to_border", {29'h0, pattern_idx}, 32'd4);
        drive(0, 400, 0, 0, 0);
        chk("border_edge", {8'h0, vga_r, vga_g, vga_b}, 32'hFFFFFF);
        drive(5, 400, 0, 0, 0);
        chk("border_inner", {8'h0, vga_r, vga_g, vga_b}, 32'h000000);
        drive(9, 9, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
`endif
        chk("wrap_to_0", {29'h0, pattern_idx}, 32'd0);

        // Reset mid-frame with a request pending
        drive(7, 7, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(7, 7, 0, 1, 0);
        drive(50, 50, 0, 0, 1);
        chk("midrst_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("midrst_idx", {29'h0, pattern_idx}, 32'd0);
        drive(0, 0, 0, 0, 0);
        chk("post_rst_fs", {31'h0, frame_start}, 32'd1);
        chk("pending_cleared", {29'h0, pattern_idx}, 32'd0);
        drive(64, 3, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
